// File: rtl/hilo_mult_unit_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply unit.
// The master drives the operation request; the slave returns busy/done and HI/LO.
interface hilo_mult_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_mult_unit.sv
// Iterative shift-add unsigned multiplier (MULTU / MADDU) owning the HI/LO pair.
// One multiplier bit is retired per clock; HI/LO change only on the completion edge.
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  hilo_mult_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   mcand_reg, mcand_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [2*WIDTH-1:0]   hilo_reg, hilo_next;
  logic [WIDTH-1:0]     mplier_reg, mplier_next;
  logic [CW-1:0]        count_reg, count_next;
  logic                 mode_reg, mode_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 accept;

  // Only MULTU (01) and MADDU (10) start an operation; op[1] alone then selects MADDU.
  assign accept = bus.start && (bus.op == 2'b01 || bus.op == 2'b10);

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    acc_next    = acc_reg;
    hilo_next   = hilo_reg;
    mplier_next = mplier_reg;
    count_next  = count_reg;
    mode_next   = mode_reg;
    busy_next   = busy_reg;
    done_next   = 1'b0;
    acc_sum     = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          mcand_next  = {{WIDTH{1'b0}}, bus.a};
          mplier_next = bus.b;
          acc_next    = '0;
          mode_next   = bus.op[1];
          count_next  = '0;
          busy_next   = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        acc_next    = acc_sum;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CW'(1);
        // Last bit retired: commit the full product (or accumulate into HI/LO).
        if (count_reg == CW'(WIDTH - 1)) begin
          hilo_next  = mode_reg ? hilo_reg + acc_sum : acc_sum;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      acc_reg    <= '0;
      hilo_reg   <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      mode_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      acc_reg    <= acc_next;
      hilo_reg   <= hilo_next;
      mplier_reg <= mplier_next;
      count_reg  <= count_next;
      mode_reg   <= mode_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.hi   = hilo_reg[2*WIDTH-1:WIDTH];
  assign bus.lo   = hilo_reg[WIDTH-1:0];
endmodule

// File: doc/hilo_mult_unit.md
Name: hilo_mult_unit

Overview:
- Iterative unsigned multiplier with the HI/LO register pair for the EX stage of mips_pipelined.
- Executes MULTU and MADDU. Supplies HI/LO to the MFHI/MFLO datapath.
- Drives busy to the hazard unit, which stalls IF/ID/EX while an operation runs.
- One product bit is retired per clock (shift-add).

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits, the product is 2*WIDTH bits.

Ports:
clk    input   1        system clock, rising-edge
rst    input   1        asynchronous, active-high reset
start  input   1        EX stage requests a multiply op this cycle
op     input   2        01 = MULTU, 10 = MADDU; 00 and 11 are no-ops
a      input   WIDTH    rs operand (multiplicand)
b      input   WIDTH    rt operand (multiplier)
busy   output  1        operation in progress; pipeline must stall
done   output  1        one-cycle pulse; HI/LO were updated on the preceding edge
hi     output  WIDTH    HI register (MFHI source)
lo     output  WIDTH    LO register (MFLO source)

Behaviour:
- Reset (async, on rst high, no clock needed): state=IDLE, hi=0, lo=0, busy=0, done=0, count=0, internal operand/accumulator registers=0. Asserting rst mid-operation aborts the operation; no partial result is ever written.
- States are IDLE and RUN.
- IDLE:
  - done=0 except for the single cycle after a completion.
  - At edge N, if start=1 and op is 01 or 10:
    - latch a into the multiplicand register, zero-extended to 2*WIDTH.
    - latch b into the multiplier register.
    - clear the 2*WIDTH product accumulator.
    - latch op into a mode bit; count=0; go to RUN; busy=1 from edge N.
  - start=1 with op 00 or 11: ignored; no state change.
- RUN, at each edge:
  - if multiplier[0]=1: accumulator += multiplicand (mod 2^(2*WIDTH)).
  - multiplicand shifts left 1; multiplier shifts right 1; count += 1.
  - At the edge where count reaches WIDTH (edge N+WIDTH):
    - MULTU: {hi,lo} <= final product.
    - MADDU: {hi,lo} <= {hi,lo} + final product, mod 2^(2*WIDTH); carry out of the MSB is discarded.
    - busy=0; done=1 for exactly one cycle; return to IDLE.
- Latency: busy is high for exactly WIDTH cycles (32 at default). done is visible in the cycle starting at edge N+WIDTH.
- The product is computed from the operand values latched at edge N. Changes on a/b/op during RUN have no effect.
- start during RUN, including at the completion edge, is ignored and not queued. The stalled pipeline re-presents the instruction, so it is accepted at the next edge seen in IDLE.
- Back-to-back operations: the earliest acceptance of a second op is edge N+WIDTH+1. It uses the just-written HI/LO as the MADDU addend.
- HI/LO hold their previous values throughout RUN. MFHI/MFLO issued behind a multiply are prevented by the stall, not by this block.
- No MTHI/MTLO support.
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start, op=01, a=3, b=5 at edge N -> busy=1 on edges N..N+31; at edge N+32, hi=0, lo=15, busy=0, done=1 for one cycle only.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 32 busy cycles. Then MADDU a=2, b=3 -> hi=0xFFFFFFFE, lo=0x00000007.
- Preload via MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, then MADDU a=0xFFFFFFFF, b=0x00000002:
  - hi:lo = 0xFFFFFFFE_00000001 + 0x00000001_FFFFFFFE = 0xFFFFFFFF_FFFFFFFF.
  - Then MADDU a=1, b=1 -> hi=0, lo=0 (wrap, carry dropped).
- During a MULTU 7*9 run:
  - pulse start with op=01, a=100, b=100 at edge N+10, and change a/b every cycle -> result lo=63, hi=0, completion still at N+32, no second op started.
  - start with op=00 in IDLE -> busy stays 0, hi/lo unchanged.
- Start MULTU 6*7 after hi:lo was set to 0:15, then assert rst asynchronously mid-cycle at N+12 -> busy, done, hi, lo go to 0 immediately. After rst deasserts, the block is IDLE and a fresh MULTU 6*7 yields lo=42 after 32 cycles.
